// File: rtl/sme_and_sched.sv
// sme_and_sched: shares one masked-AND unit between two requesters,
// pulling a fresh randomness bundle for every operation.
module sme_and_sched #(
   parameter int D       = 3,
   parameter int N       = 32,
   parameter bit POSEDGE = 1'b0,
   localparam int SM     = D - 1,
   localparam int RMAX   = D + D * (D - 1) / 2,
   localparam int RM     = RMAX - 1
) (
   input  logic                 g_clk,
   input  logic                 g_resetn,
   input  logic                 flush,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [SM:0][N-1:0]   req0_rs1,
   input  logic [SM:0][N-1:0]   req0_rs2,
   input  logic [SM:0][N-1:0]   req1_rs1,
   input  logic [SM:0][N-1:0]   req1_rs2,
   input  logic                 rng_valid,
   output logic                 rng_ready,
   input  logic [RM:0][N-1:0]   rng_data,
   output logic                 and_en,
   output logic [RM:0][N-1:0]   and_rng,
   output logic [SM:0][N-1:0]   and_rs1,
   output logic [SM:0][N-1:0]   and_rs2,
   input  logic [SM:0][N-1:0]   and_rd,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [SM:0][N-1:0]   rsp_rd,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RNG  = 2'd1,
      EXEC = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               st;
   state_t               st_nxt;
   logic                 last;
   logic                 id;
   logic                 gidx;
   logic [1:0]           grant;
   logic                 acc;
   logic                 take_rng;
   logic                 clr;
   logic [SM:0][N-1:0]   op1;
   logic [SM:0][N-1:0]   op2;
   logic [RM:0][N-1:0]   rng_q;

   // Round-robin: on contention the requester not served last wins.
   always_comb begin
      gidx  = 1'b0;
      grant = 2'b00;
      unique case (1'b1)
         (req_valid == 2'b11): gidx = ~last;
         (req_valid == 2'b10): gidx = 1'b1;
         default:              gidx = 1'b0;
      endcase
      if (st == IDLE && |req_valid)
         grant = gidx ? 2'b10 : 2'b01;
   end

   assign acc      = |grant & ~flush;
   assign take_rng = (st == RNG) & rng_valid & ~flush;
   assign clr      = flush | ((st == DONE) & rsp_ready);

   always_comb begin
      st_nxt = st;
      unique case (st)
         IDLE: if (|grant)    st_nxt = RNG;
         RNG:  if (rng_valid) st_nxt = EXEC;
         EXEC:                st_nxt = DONE;
         DONE: if (rsp_ready) st_nxt = IDLE;
      endcase
      if (flush)
         st_nxt = IDLE;
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         st   <= IDLE;
         last <= 1'b1;
         id   <= 1'b0;
      end else begin
         st <= st_nxt;
         if (acc) begin
            last <= gidx;
            id   <= gidx;
         end
      end
   end

   // Shares and randomness are wiped after use so nothing is reused.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         op1   <= '0;
         op2   <= '0;
         rng_q <= '0;
      end else if (clr) begin
         op1   <= '0;
         op2   <= '0;
         rng_q <= '0;
      end else begin
         if (acc) begin
            op1 <= gidx ? req1_rs1 : req0_rs1;
            op2 <= gidx ? req1_rs2 : req0_rs2;
         end
         if (take_rng)
            rng_q <= rng_data;
      end
   end

   assign req_ready = grant & {2{g_resetn}};
   assign rng_ready = (st == RNG);
   assign and_en    = (st == EXEC) & ~flush;
   assign rsp_valid = (st == DONE) & ~flush;
   assign rsp_id    = id;
   assign rsp_rd    = and_rd;
   assign and_rs1   = op1;
   assign and_rs2   = op2;
   assign and_rng   = rng_q;

   // Capture edge of the AND unit does not change scheduler timing.
   if (POSEDGE) begin : g_pos
      assign busy = (st != IDLE);
   end else begin : g_neg
      assign busy = (st != IDLE);
   end

endmodule
